// File: rtl/mod_mult.sv
// Sequential modular multiplier: r = (a * b) mod p, MSB-first interleaved
// double-and-add, one multiplier bit per clock, AXI-stream operands and result.
module mod_mult #(
  parameter int SIZE = 65
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_a_tdata,
  input  logic            input_a_tvalid,
  output logic            input_a_tready,
  input  logic [SIZE-1:0] input_b_tdata,
  input  logic            input_b_tvalid,
  output logic            input_b_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tuser,
  output logic            output_tvalid,
  input  logic            output_tready
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state, state_next;
  logic [SIZE-1:0] a_reg, b_reg, p_reg, r_reg;
  logic [CW-1:0]   idx;
  logic [SIZE-1:0] data_reg;
  logic            user_reg;

  logic            accept, range_err, last_step;
  logic [SIZE:0]   p_ext, t_dbl, t_red, u_sum;
  logic [SIZE-1:0] r_next;

  // All three streams transfer together or not at all; reset blocks the transfer.
  assign accept = ~rst && (state == IDLE) && input_a_tvalid && input_b_tvalid
                  && input_modulus_tvalid;

  assign input_a_tready       = accept;
  assign input_b_tready       = accept;
  assign input_modulus_tready = accept;

  // p = 0 makes both comparisons true, so it is reported as an error too.
  assign range_err = (input_a_tdata >= input_modulus_tdata)
                   || (input_b_tdata >= input_modulus_tdata);

  assign last_step = (idx == '0);

  // One reduction step with one spare bit: every intermediate stays below 2p.
  always_comb begin
    p_ext  = {1'b0, p_reg};
    t_dbl  = {r_reg, 1'b0};
    t_red  = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
    u_sum  = t_red + (b_reg[idx] ? {1'b0, a_reg} : '0);
    r_next = SIZE'((u_sum >= p_ext) ? (u_sum - p_ext) : u_sum);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = range_err ? DONE : COMPUTE;
      COMPUTE: if (last_step) state_next = DONE;
      DONE:    if (output_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Only the visible outputs need reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      user_reg <= 1'b0;
    end else if (state == IDLE && accept) begin
      if (range_err) begin
        data_reg <= '0;
        user_reg <= 1'b1;
      end
    end else if (state == COMPUTE && last_step) begin
      data_reg <= r_next;
      user_reg <= 1'b0;
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept && !range_err) begin
      a_reg <= input_a_tdata;
      b_reg <= input_b_tdata;
      p_reg <= input_modulus_tdata;
      r_reg <= '0;
      idx   <= CW'(SIZE - 1);
    end else if (state == COMPUTE) begin
      r_reg <= r_next;
      idx   <= idx - 1'b1;
    end
  end

  assign output_tdata  = data_reg;
  assign output_tuser  = user_reg;
  assign output_tvalid = (state == DONE);

endmodule

// File: tb/tb_mod_mult.sv
// Self-checking bench for mod_mult: directed boundary scenarios plus random
// operands compared against a wide-arithmetic reference model.
module tb_mod_mult;

  localparam int SIZE = 65;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] a_data, b_data, m_data;
  logic            a_valid, b_valid, m_valid;
  logic            a_ready, b_ready, m_ready;
  logic [SIZE-1:0] out_data;
  logic            out_user, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  mod_mult #(.SIZE(SIZE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_a_tdata        (a_data),
    .input_a_tvalid       (a_valid),
    .input_a_tready       (a_ready),
    .input_b_tdata        (b_data),
    .input_b_tvalid       (b_valid),
    .input_b_tready       (b_ready),
    .input_modulus_tdata  (m_data),
    .input_modulus_tvalid (m_valid),
    .input_modulus_tready (m_ready),
    .output_tdata         (out_data),
    .output_tuser         (out_user),
    .output_tvalid        (out_valid),
    .output_tready        (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: full-width product reduced with the % operator.
  function automatic void model(input logic [SIZE-1:0] a, b, p,
                                output logic [SIZE-1:0] r, output logic err);
    logic [2*SIZE-1:0] prod;
    err = (a >= p) || (b >= p);
    prod = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    r = err ? '0 : SIZE'(prod % {{SIZE{1'b0}}, p});
  endfunction

  function automatic logic [SIZE-1:0] rand65();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[SIZE-1:0];
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [SIZE-1:0] a, b, p);
    a_data = a; b_data = b; m_data = p;
    a_valid = 1'b1; b_valid = 1'b1; m_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0;
  endtask

  // Expects the DUT in IDLE with operands already driven; leaves it in DONE.
  task automatic finish_op(input string name);
    logic [SIZE-1:0] a, b, p, exp_r;
    logic exp_e;
    int n;
    a = a_data; b = b_data; p = m_data;
    model(a, b, p, exp_r, exp_e);
    checks++;
    if ({a_ready, b_ready, m_ready} !== 3'b111) begin
      failures++;
      $display("FAIL %s accept: tready=%b want 111", name, {a_ready, b_ready, m_ready});
    end
    tick();
    // Keep valids high with junk data: must be ignored while busy.
    a_data = rand65(); b_data = rand65(); m_data = rand65();
    n = 0;
    if (!exp_e) begin
      checks++;
      if ({a_ready, b_ready, m_ready, out_valid} !== 4'b0000) begin
        failures++;
        $display("FAIL %s busy: tready/valid=%b want 0000", name,
                 {a_ready, b_ready, m_ready, out_valid});
      end
      while (!out_valid && n < 200) begin
        tick();
        n++;
      end
    end
    idle_inputs();
    checks++;
    if (n !== (exp_e ? 0 : SIZE) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: got %0d valid=%b want %0d", name, n, out_valid,
               exp_e ? 0 : SIZE);
    end
    checks++;
    if (out_data !== exp_r || out_user !== exp_e) begin
      failures++;
      $display("FAIL %s result: got %h/%b want %h/%b", name, out_data, out_user, exp_r, exp_e);
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake: valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic run_op(input logic [SIZE-1:0] a, b, p, input string name);
    drive(a, b, p);
    #1;
    finish_op(name);
    handshake(name);
  endtask

  // Reset held with all valids asserted: nothing transfers, outputs at reset values.
  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(65'd7, 65'd10, 65'd23);
    tick();
    tick();
    checks++;
    if ({a_ready, b_ready, m_ready, out_valid, out_user} !== 5'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset: ready/valid/user=%b data=%h want 0", 
               {a_ready, b_ready, m_ready, out_valid, out_user}, out_data);
    end
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_consume: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_basic();
    run_op(65'd7, 65'd10, 65'd23, "basic_23");
  endtask

  task automatic test_full_width();
    logic [SIZE-1:0] p;
    p = 65'h0_FFFF_FFFF_FFFF_FFC5;
    run_op(p - 1, p - 1, p, "full_pm1");
    run_op(65'h0_8000_0000_0000_0000, 65'd2, p, "full_2pow64");
    run_op(65'd0, 65'd0, 65'd1, "p_one");
  endtask

  task automatic test_error();
    run_op(65'd23, 65'd5, 65'd23, "err_a_eq_p");
    run_op(65'd3, 65'd40, 65'd23, "err_b_gt_p");
    run_op(65'd0, 65'd0, 65'd0, "err_p_zero");
  endtask

  task automatic test_skewed_valids();
    int bad;
    bad = 0;
    a_data = 65'd9; b_data = 65'd11; m_data = 65'd31;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) a_valid = 1'b1;
      if (c == 3) b_valid = 1'b1;
      #1;
      if ({a_ready, b_ready, m_ready, out_valid} !== 4'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL skew_partial: %0d cycles with early transfer, want 0", bad);
    end
    m_valid = 1'b1;
    #1;
    finish_op("skew");
    handshake("skew");
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] held_d;
    logic held_u;
    int bad;
    drive(65'd50, 65'd77, 65'd97);
    #1;
    finish_op("bp");
    held_d = out_data; held_u = out_user;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      a_data = rand65();
      tick();
      if (out_valid !== 1'b1 || out_data !== held_d || out_user !== held_u) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure: %0d unstable cycles, want 0", bad);
    end
    // Next operation waits on the bus while the output handshake completes.
    drive(65'd0, 65'd57, 65'd101);
    out_ready = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready, m_ready} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_done_ready: tready=%b want 000", {a_ready, b_ready, m_ready});
    end
    tick();
    out_ready = 1'b0;
    finish_op("b2b_next");
    handshake("b2b_next");
  endtask

  task automatic test_reset_mid_compute();
    int seen;
    drive(65'd1234567, 65'd7654321, 65'd99999989);
    tick();
    idle_inputs();
    repeat (30) tick();
    rst = 1'b1;
    drive(65'd5, 65'd6, 65'd7);
    tick();
    checks++;
    if ({a_ready, b_ready, m_ready, out_valid, out_user} !== 5'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_mid: ready/valid/user=%b data=%h want 0",
               {a_ready, b_ready, m_ready, out_valid, out_user}, out_data);
    end
    idle_inputs();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_output: valid seen %0d cycles, want 0", seen);
    end
    run_op(65'd12, 65'd12, 65'd13, "after_reset");
  endtask

  task automatic test_random();
    logic [SIZE-1:0] p, a, b;
    for (int k = 0; k < 12; k++) begin
      p = rand65();
      if (p == '0) p = 65'd1;
      a = rand65() % p;
      b = rand65() % p;
      if (k % 4 == 3) b = p;
      run_op(a, b, p, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    idle_inputs();
    a_data = '0; b_data = '0; m_data = '0;
    test_reset();
    test_basic();
    test_full_width();
    test_error();
    test_skewed_valids();
    test_back_to_back();
    test_reset_mid_compute();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_mult.md
# mod_mult

Sequential modular multiplier computing (a · b) mod p over unsigned SIZE-bit operands, using MSB-first interleaved double-and-add reduction at one multiplier bit per clock. It consumes the AXI-stream result of the multiplicative-inverse block. In ElGamal decryption it forms m = c2 · s⁻¹ mod p, where s⁻¹ is that result. It also serves as the multiply stage of the encryption-side exponentiator.

## Interface
- SIZE, 65, operand/modulus width in bits; all values unsigned.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- input_a_tdata  in  SIZE  multiplicand a.
- input_a_tvalid  in  1  a valid.
- input_a_tready  out  1  a accepted.
- input_b_tdata  in  SIZE  multiplier b (bits scanned MSB first).
- input_b_tvalid  in  1  b valid.
- input_b_tready  out  1  b accepted.
- input_modulus_tdata  in  SIZE  modulus p.
- input_modulus_tvalid  in  1  p valid.
- input_modulus_tready  out  1  p accepted.
- output_tdata  out  SIZE  result r = a·b mod p; 0 on error.
- output_tuser  out  1  error flag: operand out of range.
- output_tvalid  out  1  result valid.
- output_tready  in  1  downstream accepts result.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE, joint accept:
  - All three tready signals equal (state==IDLE) & a_tvalid & b_tvalid & modulus_tvalid, combinationally.
  - All three streams transfer on the same edge or none does. A partial valid set is never consumed.
- On accept, range check against the input values:
  - If a ≥ p or b ≥ p (this includes p = 0): go to DONE with output_tdata=0 and output_tuser=1.
  - Otherwise: register a, b, p; set r=0; set bit counter i=SIZE-1; go to COMPUTE.
- COMPUTE, one step per cycle, with internal width SIZE+1 bits:
  - t = 2r; if t ≥ p then t = t − p.
  - u = t + (b[i] ? a : 0); if u ≥ p then u = u − p.
  - r ← u.
  - If i==0: go to DONE with output_tdata=u and output_tuser=0. Otherwise i ← i−1.
- DONE:
  - output_tvalid=1; output_tdata and output_tuser held stable.
  - On output_tready=1: go to IDLE and drop output_tvalid at that edge.
- Invariant: 0 ≤ r < p after every step. No intermediate value exceeds 2p−1 < 2^(SIZE+1).
- p = 1 with a = b = 0 is legal and gives r = 0.

## Timing
- Reset values: output_tvalid=0, output_tdata=0, output_tuser=0, all tready=0 during the reset cycle. State is IDLE after reset, and tready may rise in the cycle after rst deasserts.
- Valid operation latency: accept edge E0, then compute edges E1..E_SIZE. output_tvalid is high from E_SIZE, which is SIZE cycles after acceptance (65 by default).
- Error latency: output_tvalid is high from E0 itself, i.e. the cycle after acceptance.
- Input tready is low throughout COMPUTE and DONE. Input changes in those states are ignored.
- Back-to-back throughput: DONE exits on the output handshake edge and the next accept occurs at the following edge at earliest. Minimum interval is SIZE+2 cycles per operation.
- Backpressure: output_tready low keeps DONE indefinitely; outputs must not change.
- rst mid-COMPUTE or in DONE: abort immediately and return to IDLE with reset output values. No partial result is ever emitted.
- rst coinciding with an accept: reset wins and no operands are consumed.

## Test plan
- SIZE=65, p=23, a=7, b=10 with all valids in one cycle → single-cycle tready pulse; output_tvalid exactly 65 cycles later; output_tdata=1, output_tuser=0.
- p=18446744073709551557 (2^64−59), a=b=p−1 → output_tdata=1; a=2^63, b=2 → output_tdata=59. Confirms there is no overflow at full width.
- a=23, b=5, p=23 → output_tuser=1, output_tdata=0, output_tvalid the cycle after accept. Also p=0 with a=b=0 → error.
- Skewed valids: a_tvalid at cycle 0, b_tvalid at cycle 3, modulus_tvalid at cycle 5 → nothing accepted until cycle 5; all three transfer together.
- Backpressure and back-to-back: hold output_tready=0 for 20 cycles after valid → data, tuser and valid stay stable. Then pulse tready → next operation (p=101, a=0, b=57 → 0) is accepted on the following edge.
- rst asserted 30 cycles into COMPUTE → outputs go to 0 and no output_tvalid follows. A new operation (p=13, a=12, b=12 → 1) completes correctly afterwards.
